wb_regfile: RTL

- Write-back end of the MEM/WB pipeline interface: consumes the WB-stage control and data fields latched by the MEM/WB register.
- Selects the write-back value and commits it into the 32-entry architectural register file.
- Serves the two ID-stage read ports.
- Also exports the selected write-back value for the forwarding unit.

---
 rtl/wb_regfile_pkg.sv | 15 +
 rtl/wb_data_sel.sv | 25 ++
 rtl/wb_regfile.sv | 66 ++++++
 3 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back stage: datapath widths and MemToReg encodings.
// Imported by wb_data_sel, wb_regfile and the forwarding unit.
package wb_regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  localparam logic [1:0] MTR_ALU  = 2'b00;
  localparam logic [1:0] MTR_MEM  = 2'b01;
  localparam logic [1:0] MTR_LINK = 2'b10;

endpackage

// File: rtl/wb_data_sel.sv
// Write-back source mux with halfword sign-extension; also used by the forwarding unit.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module wb_data_sel
  import wb_regfile_pkg::*;
(
  input  logic [1:0]        mem_to_reg,
  input  logic              halfbyte,
  input  logic [DATA_W-1:0] pc_add_result,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] write_data
);

  always_comb begin
    write_data = alu_result;
    case (mem_to_reg)
      MTR_MEM:  write_data = halfbyte ? {{(DATA_W-16){read_data[15]}}, read_data[15:0]}
                                      : read_data;
      MTR_LINK: write_data = pc_add_result;
      // 2'b11 is reserved and falls through to the ALU result
      default:  write_data = alu_result;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// 32-entry register file committing the MEM/WB write-back value; two async read ports.
// Latency: write visible one edge later (same cycle when WB_BYPASS_EN is defined). No backpressure.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              WB_RegWrite,
  input  logic [1:0]        WB_MemToReg,
  input  logic              WB_halfbyte,
  input  logic [DATA_W-1:0] WB_PCAddResult,
  input  logic [DATA_W-1:0] WB_Read,
  input  logic [DATA_W-1:0] WB_ALUResult,
  input  logic [DATA_W-1:0] WB_RegDst,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WB_WriteData
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [ADDR_W-1:0] wr_idx;
  logic              wr_en;
  logic              unused_dst_hi;

  assign wr_idx        = WB_RegDst[ADDR_W-1:0];
  assign unused_dst_hi = ^WB_RegDst[DATA_W-1:ADDR_W];
  assign wr_en         = WB_RegWrite && (wr_idx != REG_ZERO);

  wb_data_sel u_data_sel (
    .mem_to_reg    (WB_MemToReg),
    .halfbyte      (WB_halfbyte),
    .pc_add_result (WB_PCAddResult),
    .read_data     (WB_Read),
    .alu_result    (WB_ALUResult),
    .write_data    (WB_WriteData)
  );

  // Only the addressed entry is enabled, so an unknown write enable cannot touch other rows.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_idx] <= WB_WriteData;
    end
  end

`ifdef WB_BYPASS_EN
  logic byp_en;
  assign byp_en = wr_en && !Reset;
`endif

  // Index 0 is forced last so it reads zero even when a bypass would match.
  always_comb begin
    ReadData1 = regs[ReadRegister1];
    ReadData2 = regs[ReadRegister2];
`ifdef WB_BYPASS_EN
    if (byp_en && (ReadRegister1 == wr_idx)) ReadData1 = WB_WriteData;
    if (byp_en && (ReadRegister2 == wr_idx)) ReadData2 = WB_WriteData;
`endif
    if (ReadRegister1 == REG_ZERO) ReadData1 = '0;
    if (ReadRegister2 == REG_ZERO) ReadData2 = '0;
  end

endmodule
